// File: rtl/conv_addr_gen.sv
// Convolution address sequencer. It walks kernel, output row/col and kernel taps, emitting one
// (in_addr, wt_addr) beat per MAC. Define CONV_ADDR_GEN_ABORT_EN to let a falling start abort a run.
module conv_addr_gen #(
    parameter int AWIDTH = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [2:0]        kern_cols,
    input  logic [7:0]        cols,
    input  logic [2:0]        kerns,
    input  logic [7:0]        stride,
    input  logic              kern_addr_mode,
    input  logic [7:0]        result_cols,
    output logic              done,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic [AWIDTH-1:0] in_addr,
    output logic [AWIDTH-1:0] wt_addr,
    output logic [2:0]        kern_idx,
    output logic              win_last,
    output logic              run_last
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [AWIDTH-1:0] ONE = AWIDTH'(1);

    state_t state, state_nxt;

    logic start_q, rise, accept, abort, fire, empty_cfg;
    logic load, advance, finish;

    logic [2:0]        cfg_k, cfg_n;
    logic [7:0]        cfg_w, cfg_s, cfg_r;
    logic              cfg_mode;
    logic [AWIDTH-1:0] row_step;
    logic [15:0]       step_prod;

    logic [2:0]        kx, ky;
    logic [7:0]        col, row;
    logic [AWIDTH-1:0] row_base, col_base, tap_base, kern_base;

    logic [2:0]        kx_nxt, ky_nxt, kern_nxt;
    logic [7:0]        col_nxt, row_nxt;
    logic [AWIDTH-1:0] row_base_nxt, col_base_nxt, tap_base_nxt, kern_base_nxt;
    logic [AWIDTH-1:0] in_nxt, wt_nxt;
    logic              win_last_nxt, run_last_nxt;

    assign rise      = start & ~start_q;
    assign accept    = rise && (state != RUN);
    assign fire      = addr_valid & addr_ready;
    assign empty_cfg = (kern_cols == 3'd0) || (kerns == 3'd0) || (result_cols == 8'd0);

    // Row step S*W is formed once per run from the configuration, never per beat.
    assign step_prod = 16'(stride) * 16'(cols);

`ifdef CONV_ADDR_GEN_ABORT_EN
    assign abort = (state == RUN) && start_q && !start;
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_nxt = state;
        load      = 1'b0;
        advance   = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (rise) begin
                    state_nxt = empty_cfg ? DONE : RUN;
                    load      = !empty_cfg;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (fire) begin
                    if (run_last) begin
                        state_nxt = DONE;
                        finish    = 1'b1;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next beat: taps advance linearly, window/row/kernel steps reload from the base accumulators.
    always_comb begin
        kx_nxt        = kx + 3'd1;
        ky_nxt        = ky;
        col_nxt       = col;
        row_nxt       = row;
        kern_nxt      = kern_idx;
        row_base_nxt  = row_base;
        col_base_nxt  = col_base;
        tap_base_nxt  = tap_base;
        kern_base_nxt = kern_base;
        in_nxt        = in_addr + ONE;
        wt_nxt        = wt_addr + ONE;
        if (kx == cfg_k - 3'd1) begin
            kx_nxt = '0;
            if (ky != cfg_k - 3'd1) begin
                ky_nxt       = ky + 3'd1;
                tap_base_nxt = tap_base + AWIDTH'(cfg_w);
                in_nxt       = tap_base_nxt;
            end else begin
                ky_nxt = '0;
                wt_nxt = kern_base;
                if (col != cfg_r - 8'd1) begin
                    col_nxt      = col + 8'd1;
                    col_base_nxt = col_base + AWIDTH'(cfg_s);
                end else begin
                    col_nxt = '0;
                    if (row != cfg_r - 8'd1) begin
                        row_nxt      = row + 8'd1;
                        row_base_nxt = row_base + row_step;
                    end else begin
                        row_nxt      = '0;
                        kern_nxt     = kern_idx + 3'd1;
                        row_base_nxt = '0;
                        // Linear weights: the next kernel starts right after the last tap.
                        if (!cfg_mode) begin
                            kern_base_nxt = wt_addr + ONE;
                            wt_nxt        = kern_base_nxt;
                        end
                    end
                    col_base_nxt = row_base_nxt;
                end
                tap_base_nxt = col_base_nxt;
                in_nxt       = col_base_nxt;
            end
        end
        win_last_nxt = (kx_nxt == cfg_k - 3'd1) && (ky_nxt == cfg_k - 3'd1);
        run_last_nxt = win_last_nxt && (col_nxt == cfg_r - 8'd1) &&
                       (row_nxt == cfg_r - 8'd1) && (kern_nxt == cfg_n - 3'd1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            start_q    <= 1'b0;
            cfg_k      <= '0;
            cfg_n      <= '0;
            cfg_w      <= '0;
            cfg_s      <= '0;
            cfg_r      <= '0;
            cfg_mode   <= 1'b0;
            row_step   <= '0;
            kx         <= '0;
            ky         <= '0;
            col        <= '0;
            row        <= '0;
            row_base   <= '0;
            col_base   <= '0;
            tap_base   <= '0;
            kern_base  <= '0;
            done       <= 1'b0;
            addr_valid <= 1'b0;
            in_addr    <= '0;
            wt_addr    <= '0;
            kern_idx   <= '0;
            win_last   <= 1'b0;
            run_last   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state   <= state_nxt;
            start_q <= start;
            if (accept) begin
                cfg_k    <= kern_cols;
                cfg_n    <= kerns;
                cfg_w    <= cols;
                cfg_s    <= stride;
                cfg_r    <= result_cols;
                cfg_mode <= kern_addr_mode;
                row_step <= AWIDTH'(step_prod);
            end
            if (load) begin
                addr_valid <= 1'b1;
                kx         <= '0;
                ky         <= '0;
                col        <= '0;
                row        <= '0;
                row_base   <= '0;
                col_base   <= '0;
                tap_base   <= '0;
                kern_base  <= '0;
                in_addr    <= '0;
                wt_addr    <= '0;
                kern_idx   <= '0;
                // First-beat flags come straight from the inputs being latched this edge.
                win_last   <= (kern_cols == 3'd1);
                run_last   <= (kern_cols == 3'd1) && (result_cols == 8'd1) && (kerns == 3'd1);
            end else if (advance) begin
                kx        <= kx_nxt;
                ky        <= ky_nxt;
                col       <= col_nxt;
                row       <= row_nxt;
                row_base  <= row_base_nxt;
                col_base  <= col_base_nxt;
                tap_base  <= tap_base_nxt;
                kern_base <= kern_base_nxt;
                in_addr   <= in_nxt;
                wt_addr   <= wt_nxt;
                kern_idx  <= kern_nxt;
                win_last  <= win_last_nxt;
                run_last  <= run_last_nxt;
            end else if (finish || abort) begin
                addr_valid <= 1'b0;
            end
            if (load) begin
                done <= 1'b0;
            end else if (finish || (accept && empty_cfg)) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_conv_addr_gen.sv
// Directed bench for conv_addr_gen: reset, addressing patterns, kernel modes, backpressure,
// zero configuration, start drop during a run and reset in mid-run.
module tb_conv_addr_gen;

    localparam int AWIDTH = 16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [2:0]        kern_cols = '0;
    logic [7:0]        cols = '0;
    logic [2:0]        kerns = '0;
    logic [7:0]        stride = '0;
    logic              kern_addr_mode = 1'b0;
    logic [7:0]        result_cols = '0;
    logic              addr_ready = 1'b0;
    logic              done, addr_valid, win_last, run_last;
    logic [AWIDTH-1:0] in_addr, wt_addr;
    logic [2:0]        kern_idx;

    int n_cmp = 0;
    int n_fail = 0;

    logic [15:0] got_in[$], got_wt[$], exp_in[$], exp_wt[$];
    logic [2:0]  got_k[$], exp_k[$];
    logic        got_wl[$], got_rl[$], exp_wl[$], exp_rl[$];
    int          cyc_first, cyc_last, n_stall_chg;
    bit          saw_last;

    conv_addr_gen #(.AWIDTH(AWIDTH)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .kern_cols(kern_cols), .cols(cols),
        .kerns(kerns), .stride(stride), .kern_addr_mode(kern_addr_mode),
        .result_cols(result_cols), .done(done), .addr_valid(addr_valid),
        .addr_ready(addr_ready), .in_addr(in_addr), .wt_addr(wt_addr), .kern_idx(kern_idx),
        .win_last(win_last), .run_last(run_last)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] gin(input int i);
        return (i < got_in.size()) ? got_in[i] : 16'hFFFF;
    endfunction
    function automatic logic [15:0] gwt(input int i);
        return (i < got_wt.size()) ? got_wt[i] : 16'hFFFF;
    endfunction
    function automatic logic [2:0] gk(input int i);
        return (i < got_k.size()) ? got_k[i] : 3'h7;
    endfunction
    function automatic logic gwl(input int i);
        return (i < got_wl.size()) ? got_wl[i] : 1'b0;
    endfunction
    function automatic logic grl(input int i);
        return (i < got_rl.size()) ? got_rl[i] : 1'b0;
    endfunction

    // Reference beat list straight from the closed-form address equations.
    task automatic build_expected(input int k_, input int w_, input int n_, input int s_,
                                  input int m_, input int r_);
        exp_in.delete(); exp_wt.delete(); exp_k.delete(); exp_wl.delete(); exp_rl.delete();
        for (int k = 0; k < n_; k++)
            for (int r = 0; r < r_; r++)
                for (int c = 0; c < r_; c++)
                    for (int ky = 0; ky < k_; ky++)
                        for (int kx = 0; kx < k_; kx++) begin
                            exp_in.push_back(16'((r * s_ + ky) * w_ + c * s_ + kx));
                            exp_wt.push_back(16'(m_ != 0 ? ky * k_ + kx : k * k_ * k_ + ky * k_ + kx));
                            exp_k.push_back(3'(k));
                            exp_wl.push_back(kx == k_ - 1 && ky == k_ - 1);
                            exp_rl.push_back(kx == k_ - 1 && ky == k_ - 1 && c == r_ - 1 &&
                                             r == r_ - 1 && k == n_ - 1);
                        end
    endtask

    function automatic int seq_diff(output int first);
        int bad = 0;
        first = -1;
        for (int i = 0; i < exp_in.size(); i++)
            if (gin(i) !== exp_in[i] || gwt(i) !== exp_wt[i] || gk(i) !== exp_k[i] ||
                gwl(i) !== exp_wl[i] || grl(i) !== exp_rl[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        return bad;
    endfunction

    task automatic kick(input logic [2:0] k, input logic [7:0] w, input logic [2:0] n,
                        input logic [7:0] s, input logic m, input logic [7:0] r);
        start = 1'b0;
        @(negedge clk);
        kern_cols = k; cols = w; kerns = n; stride = s; kern_addr_mode = m; result_cols = r;
        start = 1'b1;
    endtask

    // Called at a negedge; records transferred beats until run_last, stop_at beats, or the bound.
    task automatic collect(input bit rand_ready, input int stop_at, input bit clear);
        logic [37:0] snap, prev_snap;
        bit stalled = 1'b0;
        prev_snap = '0;
        if (clear) begin
            got_in.delete(); got_wt.delete(); got_k.delete(); got_wl.delete(); got_rl.delete();
        end
        saw_last = 1'b0; n_stall_chg = 0; cyc_first = -1; cyc_last = -1;
        for (int i = 0; i < 2000; i++) begin
            snap = {addr_valid, in_addr, wt_addr, kern_idx, win_last, run_last};
            if (stalled && snap !== prev_snap) n_stall_chg++;
            addr_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled    = addr_valid && !addr_ready;
            prev_snap  = snap;
            if (addr_valid && addr_ready) begin
                if (cyc_first < 0) cyc_first = i;
                got_in.push_back(in_addr); got_wt.push_back(wt_addr); got_k.push_back(kern_idx);
                got_wl.push_back(win_last); got_rl.push_back(run_last);
                if (run_last) begin
                    saw_last = 1'b1;
                    cyc_last = i;
                    return;
                end
                if (stop_at != 0 && got_in.size() == stop_at) return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if ({done, addr_valid, win_last, run_last, kern_idx} !== 7'd0) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000000", {done, addr_valid, win_last, run_last, kern_idx}); end
        n_cmp++; if ({in_addr, wt_addr} !== 32'd0) begin n_fail++; $display("FAIL reset_addr: got in=%0d wt=%0d expected 0/0", in_addr, wt_addr); end
        reset_n = 1'b1;
        @(negedge clk);
        n_cmp++; if ({done, addr_valid} !== 2'b00) begin n_fail++; $display("FAIL idle_after_reset: got done/valid=%b expected 00", {done, addr_valid}); end
    endtask

    task automatic test_zero_cfg();
        bit any_valid = 1'b0;
        kick(3'd0, 8'd5, 3'd1, 8'd1, 1'b0, 8'd3);
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_pre_done: got %b expected 0", done); end
        @(negedge clk);
        n_cmp++; if ({done, addr_valid} !== 2'b10) begin n_fail++; $display("FAIL zero_done: got done/valid=%b expected 10", {done, addr_valid}); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (addr_valid) any_valid = 1'b1;
        end
        n_cmp++; if (any_valid !== 1'b0) begin n_fail++; $display("FAIL zero_no_beats: got valid seen=%b expected 0", any_valid); end
        kick(3'd2, 8'd5, 3'd1, 8'd2, 1'b0, 8'd2);
        @(negedge clk);
        n_cmp++; if ({done, addr_valid} !== 2'b01) begin n_fail++; $display("FAIL zero_rerun_start: got done/valid=%b expected 01", {done, addr_valid}); end
        collect(1'b0, 0, 1'b1);
        n_cmp++; if (got_in.size() !== 16 || !saw_last) begin n_fail++; $display("FAIL zero_rerun_beats: got %0d beats last=%b expected 16 and 1", got_in.size(), saw_last); end
        @(negedge clk);
        n_cmp++; if ({done, addr_valid} !== 2'b10) begin n_fail++; $display("FAIL zero_rerun_done: got done/valid=%b expected 10", {done, addr_valid}); end
    endtask

    task automatic test_basic();
        logic [15:0] win0 [9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
        int bad = 0;
        int first;
        kick(3'd3, 8'd5, 3'd1, 8'd1, 1'b0, 8'd3);
        n_cmp++; if (addr_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pre_valid: got %b expected 0", addr_valid); end
        @(negedge clk);
        collect(1'b0, 0, 1'b1);
        build_expected(3, 5, 1, 1, 0, 3);
        n_cmp++; if (got_in.size() !== 81) begin n_fail++; $display("FAIL basic_count: got %0d expected 81", got_in.size()); end
        for (int i = 0; i < 9; i++) if (gin(i) !== win0[i] || gwt(i) !== 16'(i)) bad++;
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL basic_first_window: got %0d bad taps, in[0..2]=%0d,%0d,%0d expected 0,1,2", bad, gin(0), gin(1), gin(2)); end
        n_cmp++; if (gin(9) !== 16'd1) begin n_fail++; $display("FAIL basic_second_window: got %0d expected 1", gin(9)); end
        n_cmp++; if (gin(80) !== 16'd24 || grl(80) !== 1'b1) begin n_fail++; $display("FAIL basic_last_beat: got in=%0d run_last=%b expected 24/1", gin(80), grl(80)); end
        n_cmp++; if (cyc_first !== 0 || cyc_last !== 80) begin n_fail++; $display("FAIL basic_timing: got first=%0d last=%0d expected 0/80", cyc_first, cyc_last); end
        bad = seq_diff(first);
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL basic_sequence: got %0d bad beats (first %0d in=%0d wt=%0d) expected 0", bad, first, gin(first), gwt(first)); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_early: got %b expected 0", done); end
        @(negedge clk);
        n_cmp++; if ({done, addr_valid} !== 2'b10) begin n_fail++; $display("FAIL basic_done: got done/valid=%b expected 10", {done, addr_valid}); end
    endtask

    task automatic test_stride();
        logic [15:0] hin [16] = '{0, 1, 5, 6, 2, 3, 7, 8, 10, 11, 15, 16, 12, 13, 17, 18};
        int bad = 0;
        kick(3'd2, 8'd5, 3'd1, 8'd2, 1'b0, 8'd2);
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL stride_done_sticky: got %b expected 1", done); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL stride_done_clear: got %b expected 0", done); end
        collect(1'b0, 0, 1'b1);
        n_cmp++; if (got_in.size() !== 16) begin n_fail++; $display("FAIL stride_count: got %0d expected 16", got_in.size()); end
        n_cmp++; if (gin(4) !== 16'd2 || gin(8) !== 16'd10) begin n_fail++; $display("FAIL stride_windows: got %0d,%0d expected 2,10", gin(4), gin(8)); end
        for (int i = 0; i < 16; i++)
            if (gin(i) !== hin[i] || gwt(i) !== 16'(i % 4) || gwl(i) !== (i % 4 == 3) || grl(i) !== (i == 15)) bad++;
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL stride_sequence: got %0d bad beats expected 0", bad); end
        @(negedge clk);
    endtask

    task automatic test_kernels();
        int bad = 0;
        int first;
        kick(3'd3, 8'd3, 3'd2, 8'd1, 1'b0, 8'd1);
        @(negedge clk);
        collect(1'b0, 0, 1'b1);
        for (int i = 0; i < 18; i++)
            if (gk(i) !== 3'(i / 9) || gwt(i) !== 16'(i) || gin(i) !== 16'(i % 9)) bad++;
        n_cmp++; if (bad != 0 || got_in.size() !== 18) begin n_fail++; $display("FAIL kern_linear: got %0d bad of %0d beats, wt[9]=%0d expected 0 bad of 18, wt[9]=9", bad, got_in.size(), gwt(9)); end
        @(negedge clk);
        kick(3'd3, 8'd3, 3'd2, 8'd1, 1'b1, 8'd1);
        @(negedge clk);
        collect(1'b0, 0, 1'b1);
        bad = 0;
        for (int i = 9; i < 18; i++) if (gk(i) !== 3'd1 || gwt(i) !== 16'(i - 9)) bad++;
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL kern_per_kernel: got %0d bad beats, wt[9]=%0d k[9]=%0d expected 0 bad, 0/1", bad, gwt(9), gk(9)); end
        build_expected(3, 3, 2, 1, 1, 1);
        bad = seq_diff(first);
        n_cmp++; if (bad != 0 || got_in.size() !== 18) begin n_fail++; $display("FAIL kern_per_kernel_seq: got %0d bad beats (first %0d) size %0d expected 0/18", bad, first, got_in.size()); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int bad, first;
        kick(3'd3, 8'd5, 3'd1, 8'd1, 1'b0, 8'd3);
        @(negedge clk);
        collect(1'b1, 0, 1'b1);
        build_expected(3, 5, 1, 1, 0, 3);
        n_cmp++; if (got_in.size() !== 81 || !saw_last) begin n_fail++; $display("FAIL bp_count: got %0d beats last=%b expected 81/1", got_in.size(), saw_last); end
        bad = seq_diff(first);
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL bp_sequence: got %0d bad beats (first %0d) expected 0", bad, first); end
        n_cmp++; if (n_stall_chg != 0) begin n_fail++; $display("FAIL bp_stall_stable: got %0d output changes during stalls expected 0", n_stall_chg); end
        addr_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_start_drop();
        kick(3'd3, 8'd5, 3'd1, 8'd1, 1'b0, 8'd3);
        @(negedge clk);
        collect(1'b0, 40, 1'b1);
        n_cmp++; if (got_in.size() !== 40) begin n_fail++; $display("FAIL drop_prefix: got %0d beats expected 40", got_in.size()); end
        start = 1'b0;
        @(negedge clk);
`ifdef CONV_ADDR_GEN_ABORT_EN
        n_cmp++; if ({done, addr_valid} !== 2'b00) begin n_fail++; $display("FAIL abort_stop: got done/valid=%b expected 00", {done, addr_valid}); end
        @(negedge clk);
        n_cmp++; if ({done, addr_valid} !== 2'b00) begin n_fail++; $display("FAIL abort_idle: got done/valid=%b expected 00", {done, addr_valid}); end
`else
        begin
            int bad, first;
            collect(1'b0, 0, 1'b0);
            build_expected(3, 5, 1, 1, 0, 3);
            bad = seq_diff(first);
            n_cmp++; if (bad != 0 || got_in.size() !== 81) begin n_fail++; $display("FAIL drop_ignored: got %0d bad of %0d beats expected 0 bad of 81", bad, got_in.size()); end
            @(negedge clk);
            n_cmp++; if ({done, addr_valid} !== 2'b10) begin n_fail++; $display("FAIL drop_done: got done/valid=%b expected 10", {done, addr_valid}); end
        end
`endif
    endtask

    task automatic test_reset_mid_run();
        int bad, first;
        kick(3'd3, 8'd5, 3'd1, 8'd1, 1'b0, 8'd3);
        @(negedge clk);
        collect(1'b0, 40, 1'b1);
        n_cmp++; if (addr_valid !== 1'b1 || gin(39) !== 16'd11) begin n_fail++; $display("FAIL rst_prefix: got valid=%b in[39]=%0d expected 1/11", addr_valid, gin(39)); end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if ({done, addr_valid, win_last, run_last, kern_idx, in_addr, wt_addr} !== 39'd0) begin n_fail++; $display("FAIL rst_async: got valid=%b in=%0d wt=%0d k=%0d expected all 0", addr_valid, in_addr, wt_addr, kern_idx); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        collect(1'b0, 0, 1'b1);
        build_expected(3, 5, 1, 1, 0, 3);
        bad = seq_diff(first);
        n_cmp++; if (cyc_first !== 0 || gin(0) !== 16'd0) begin n_fail++; $display("FAIL rst_restart: got first cycle=%0d in[0]=%0d expected 0/0", cyc_first, gin(0)); end
        n_cmp++; if (bad != 0 || got_in.size() !== 81) begin n_fail++; $display("FAIL rst_rerun: got %0d bad of %0d beats expected 0 bad of 81", bad, got_in.size()); end
        @(negedge clk);
        n_cmp++; if ({done, addr_valid} !== 2'b10) begin n_fail++; $display("FAIL rst_rerun_done: got done/valid=%b expected 10", {done, addr_valid}); end
    endtask

    initial begin
        test_reset();
        test_zero_cfg();
        test_basic();
        test_stride();
        test_kernels();
        test_backpressure();
        test_start_drop();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test expected completion within bound");
        $fatal(1, "watchdog expired");
    end

endmodule
